id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 instD  input  32  instruction from the IF/ID register.
REQ-004 pcD  input  32  PC of instD.
REQ-005 pcplus4D  input  32  PC+4 of instD.
REQ-006 regwriteW  input  1  writeback enable.
REQ-007 rdW  input  5  writeback destination register.
REQ-008 resultW  input  32  writeback data.
REQ-009 flushE  input  1  inserts a bubble into the ID/EX register.
REQ-010 regwriteE, memwriteE, resultsrcE, branchE, alusrcE  output  1 each  registered control bits.
REQ-011 alucontrolE  output  3  registered ALU operation.
REQ-012 rd1E, rd2E, immextE, pcE, pcplus4E  output  32 each  registered operands, immediate and PCs.
REQ-013 rs1E, rs2E, rdE  output  5 each  registered register addresses, consumed by the forwarding/hazard logic.

Function
REQ-014 The block SHALL decode opcode instD[6:0] as follows:
- 0110011 = R-type
- 0010011 = I-ALU
- 0000011 = load
- 0100011 = store
- 1100011 = branch
- any other opcode = bubble (all controls 0, immediate 0).
REQ-015 Control bits, listed as regwrite, alusrc, memwrite, resultsrc, branch, SHALL be:
- R-type: 1,0,0,0,0
- I-ALU: 1,1,0,0,0
- load: 1,1,0,1,0
- store: 0,1,1,0,0
- branch: 0,0,0,0,1.
REQ-016 alucontrol SHALL be set as follows:
- load and store: 000 (add)
- branch: 001 (sub)
- R-type and I-ALU, selected by funct3 instD[14:12]: 000 gives add (000), or sub (001) only when R-type and instD[30]=1; 111 gives and (010); 110 gives or (011); 010 gives slt (101); any other funct3 gives 000.
REQ-017 The immediate SHALL be formed as follows:
- I-ALU and load: sign-extended instD[31:20]
- store: sign-extended instD[31:25] concatenated with instD[11:7]
- branch: sign-extended instD[31], instD[7], instD[30:25], instD[11:8], then a zero LSB
- R-type and bubble: 0.
REQ-018 The register file SHALL hold 32 x 32-bit registers and be read combinationally at rs1=instD[19:15] and rs2=instD[24:20]; x0 always reads 0.
REQ-019 The register file SHALL be written on the rising edge when regwriteW=1 and rdW is nonzero; writes to x0 are dropped.
REQ-020 The register file SHALL write through: when regwriteW=1, rdW is nonzero and rdW matches rs1 or rs2 in the same cycle, that read returns resultW.
REQ-021 The ID/EX register SHALL capture every rising edge: all controls, rd1, rd2, the immediate, rs1, rs2, rd=instD[11:7], pcD and pcplus4D; latency is exactly 1 cycle and there is no stall input.
REQ-022 When flushE=1 at an edge, every ID/EX output SHALL become 0; the register-file write in that same cycle still occurs.
REQ-023 For store and branch, rdE SHALL still carry instD[11:7], with regwriteE=0.

Reset
REQ-024 While rst=1, all ID/EX outputs and all 32 registers SHALL be 0 immediately, independent of clk.
REQ-025 rst SHALL take priority over flushE and regwriteW; no register-file write occurs during reset.
REQ-026 The first capture after reset SHALL occur on the first rising edge with rst=0; an instruction in flight when reset asserts is discarded.

Verification
REQ-027 Asynchronous reset: assert rst between edges while ID/EX holds data -> all outputs read 0 before the next edge.
REQ-028 R-type: x1=5, x2=7, instD=0x002081B3 (add x3,x1,x2) -> after the next edge: regwriteE=1, alusrcE=0, alucontrolE=000, rd1E=5, rd2E=7, rdE=3, immextE=0.
REQ-029 Write-through: regwriteW=1, rdW=1, resultW=0x00001234 in the same cycle as instD reads rs1=x1 -> rd1E=0x00001234 after the edge.
REQ-030 x0 protection: regwriteW=1, rdW=0, resultW=0xFFFFFFFF, then read x0 -> rd1E=0.
REQ-031 Branch: instD=0xFE208CE3 (beq x1,x2,-8) -> branchE=1, regwriteE=0, alucontrolE=001, immextE=0xFFFFFFF8.
REQ-032 Flush: flushE=1 with a valid R-type in instD -> all ID/EX outputs 0 after the edge; a concurrent writeback to x5 of 0xA5 is visible when x5 is read next cycle.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage of a five-stage RV32I subset pipeline: control decode, immediate
// generation, 32x32 register file with write-through, and the ID/EX register.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instD,
  input  logic [31:0] pcD,
  input  logic [31:0] pcplus4D,
  input  logic        regwriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] resultW,
  input  logic        flushE,
  output logic        regwriteE,
  output logic        memwriteE,
  output logic        resultsrcE,
  output logic        branchE,
  output logic        alusrcE,
  output logic [2:0]  alucontrolE,
  output logic [31:0] rd1E,
  output logic [31:0] rd2E,
  output logic [31:0] immextE,
  output logic [31:0] pcE,
  output logic [31:0] pcplus4E,
  output logic [4:0]  rs1E,
  output logic [4:0]  rs2E,
  output logic [4:0]  rdE
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        resultsrc;
    logic        branch;
    logic        alusrc;
    logic [2:0]  alucontrol;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immext;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rf_reg [32];
  logic [31:0] rd1_val;
  logic [31:0] rd2_val;
  logic        rf_wen;
  idex_t       idex_next;
  idex_t       idex_reg;

  assign opcode   = instD[6:0];
  assign funct3   = instD[14:12];
  assign rs1_addr = instD[19:15];
  assign rs2_addr = instD[24:20];
  assign rf_wen   = regwriteW && (rdW != 5'd0);

  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  alu_from_funct3 = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  alu_from_funct3 = ALU_AND;
      3'b110:  alu_from_funct3 = ALU_OR;
      3'b010:  alu_from_funct3 = ALU_SLT;
      default: alu_from_funct3 = ALU_ADD;
    endcase
  endfunction

  // Register file: x0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (rf_wen) begin
      rf_reg[rdW] <= resultW;
    end
  end

  // Write-through lets the writeback value reach this cycle's read.
  always_comb begin
    rd1_val = rf_reg[rs1_addr];
    rd2_val = rf_reg[rs2_addr];
    if (rf_wen && (rdW == rs1_addr)) rd1_val = resultW;
    if (rf_wen && (rdW == rs2_addr)) rd2_val = resultW;
    if (rs1_addr == 5'd0) rd1_val = '0;
    if (rs2_addr == 5'd0) rd2_val = '0;
  end

  always_comb begin
    idex_next         = '0;
    idex_next.rd1     = rd1_val;
    idex_next.rd2     = rd2_val;
    idex_next.pc      = pcD;
    idex_next.pcplus4 = pcplus4D;
    idex_next.rs1     = rs1_addr;
    idex_next.rs2     = rs2_addr;
    idex_next.rd      = instD[11:7];
    case (opcode)
      OP_R: begin
        idex_next.regwrite   = 1'b1;
        idex_next.alucontrol = alu_from_funct3(funct3, instD[30]);
      end
      OP_I_ALU: begin
        idex_next.regwrite   = 1'b1;
        idex_next.alusrc     = 1'b1;
        idex_next.alucontrol = alu_from_funct3(funct3, 1'b0);
        idex_next.immext     = {{20{instD[31]}}, instD[31:20]};
      end
      OP_LOAD: begin
        idex_next.regwrite   = 1'b1;
        idex_next.alusrc     = 1'b1;
        idex_next.resultsrc  = 1'b1;
        idex_next.immext     = {{20{instD[31]}}, instD[31:20]};
      end
      OP_STORE: begin
        idex_next.alusrc     = 1'b1;
        idex_next.memwrite   = 1'b1;
        idex_next.immext     = {{20{instD[31]}}, instD[31:25], instD[11:7]};
      end
      OP_BRANCH: begin
        idex_next.branch     = 1'b1;
        idex_next.alucontrol = ALU_SUB;
        idex_next.immext     = {{20{instD[31]}}, instD[7], instD[30:25], instD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_reg <= '0;
    end else if (flushE) begin
      idex_reg <= '0;
    end else begin
      idex_reg <= idex_next;
    end
  end

  assign regwriteE   = idex_reg.regwrite;
  assign memwriteE   = idex_reg.memwrite;
  assign resultsrcE  = idex_reg.resultsrc;
  assign branchE     = idex_reg.branch;
  assign alusrcE     = idex_reg.alusrc;
  assign alucontrolE = idex_reg.alucontrol;
  assign rd1E        = idex_reg.rd1;
  assign rd2E        = idex_reg.rd2;
  assign immextE     = idex_reg.immext;
  assign pcE         = idex_reg.pc;
  assign pcplus4E    = idex_reg.pcplus4;
  assign rs1E        = idex_reg.rs1;
  assign rs2E        = idex_reg.rs2;
  assign rdE         = idex_reg.rd;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by random instructions,
// all checked against a table-driven decode model and a reference register array.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instD, pcD, pcplus4D, resultW;
  logic        regwriteW, flushE;
  logic [4:0]  rdW;
  logic        regwriteE, memwriteE, resultsrcE, branchE, alusrcE;
  logic [2:0]  alucontrolE;
  logic [31:0] rd1E, rd2E, immextE, pcE, pcplus4E;
  logic [4:0]  rs1E, rs2E, rdE;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  typedef struct packed {
    logic        rw, mw, rs, br, as;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } idex_t;

  logic [31:0] mregs [32];
  idex_t       obs;

  id_stage dut (
    .clk(clk), .rst(rst), .instD(instD), .pcD(pcD), .pcplus4D(pcplus4D),
    .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .flushE(flushE),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .resultsrcE(resultsrcE),
    .branchE(branchE), .alusrcE(alusrcE), .alucontrolE(alucontrolE),
    .rd1E(rd1E), .rd2E(rd2E), .immextE(immextE), .pcE(pcE), .pcplus4E(pcplus4E),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE)
  );

  always #5 clk = ~clk;

  assign obs = '{regwriteE, memwriteE, resultsrcE, branchE, alusrcE, alucontrolE,
                 rd1E, rd2E, immextE, pcE, pcplus4E, rs1E, rs2E, rdE};

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (regwriteW && rdW == a) return resultW;
    return mregs[a];
  endfunction

  // Decode from the instruction-class table: {regwrite, alusrc, memwrite, resultsrc, branch}.
  function automatic idex_t expect_now();
    idex_t e;
    logic [4:0] ctl;
    int kind;
    e = '0;
    if (rst || flushE) return e;
    case (instD[6:0])
      7'h33: kind = 0;
      7'h13: kind = 1;
      7'h03: kind = 2;
      7'h23: kind = 3;
      7'h63: kind = 4;
      default: kind = 5;
    endcase
    case (kind)
      0: ctl = 5'b10000;
      1: ctl = 5'b11000;
      2: ctl = 5'b11010;
      3: ctl = 5'b01100;
      4: ctl = 5'b00001;
      default: ctl = 5'b00000;
    endcase
    {e.rw, e.as, e.mw, e.rs, e.br} = ctl;
    if (kind == 4) e.alu = 3'd1;
    else if (kind <= 1) begin
      if (instD[14:12] == 3'd0) e.alu = (kind == 0 && instD[30]) ? 3'd1 : 3'd0;
      else if (instD[14:12] == 3'd7) e.alu = 3'd2;
      else if (instD[14:12] == 3'd6) e.alu = 3'd3;
      else if (instD[14:12] == 3'd2) e.alu = 3'd5;
      else e.alu = 3'd0;
    end
    if (kind == 1 || kind == 2) e.imm = 32'($signed(instD[31:20]));
    else if (kind == 3) e.imm = 32'($signed({instD[31:25], instD[11:7]}));
    else if (kind == 4) e.imm = 32'($signed({instD[31], instD[7], instD[30:25], instD[11:8], 1'b0}));
    e.rs1 = instD[19:15];
    e.rs2 = instD[24:20];
    e.rd  = instD[11:7];
    e.rd1 = mread(e.rs1);
    e.rd2 = mread(e.rs2);
    e.pc  = pcD;
    e.pc4 = pcplus4D;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [191:0] o, input logic [191:0] x);
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic step(input string tag);
    idex_t e;
    e = expect_now();
    @(posedge clk);
    #1;
    if (rst) for (int i = 0; i < 32; i++) mregs[i] = '0;
    else if (regwriteW && rdW != 0) mregs[rdW] = resultW;
    n_txn++;
    $display("[TB] txn %0d %s inst=%h rst=%b flush=%b wb=%b x%0d<=%h", n_txn, tag,
             instD, rst, flushE, regwriteW, rdW, resultW);
    chk(tag, 192'(obs), 192'(e));
  endtask

  task automatic drive(input logic [31:0] i, input logic wb, input logic [4:0] rd,
                       input logic [31:0] res, input logic fl);
    instD = i; regwriteW = wb; rdW = rd; resultW = res; flushE = fl;
    pcD = $urandom; pcplus4D = pcD + 4;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [31:0] ri;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h00};
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    rst = 1'b1;
    drive(32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    chk("reset_state", 192'(obs), 192'(0));
    step("reset_hold");
    rst = 1'b0;

    drive(32'h0, 1'b1, 5'd1, 32'd5, 1'b0);         step("wr_x1");
    drive(32'h0, 1'b1, 5'd2, 32'd7, 1'b0);         step("wr_x2");
    drive(32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0);  step("rtype_add");
    chk("rt_regwrite", 192'(regwriteE), 192'(1));
    chk("rt_rd1", 192'(rd1E), 192'(5));
    chk("rt_rd2", 192'(rd2E), 192'(7));
    chk("rt_rd", 192'(rdE), 192'(3));

    drive(32'h002081B3, 1'b1, 5'd1, 32'h1234, 1'b0); step("write_through");
    chk("wt_rd1", 192'(rd1E), 192'(32'h1234));

    drive(32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);  step("wr_x0");
    drive(32'h00000033, 1'b0, 5'd0, 32'd0, 1'b0);  step("rd_x0");
    chk("x0_rd1", 192'(rd1E), 192'(0));

    drive(32'hFE208CE3, 1'b0, 5'd0, 32'd0, 1'b0);  step("branch");
    chk("br_branch", 192'(branchE), 192'(1));
    chk("br_imm", 192'(immextE), 192'(32'hFFFFFFF8));
    chk("br_alu", 192'(alucontrolE), 192'(1));

    drive(32'h002081B3, 1'b1, 5'd5, 32'hA5, 1'b1); step("flush");
    chk("fl_zero", 192'(obs), 192'(0));
    drive(32'h00028333, 1'b0, 5'd0, 32'd0, 1'b0);  step("rd_x5");
    chk("fl_x5", 192'(rd1E), 192'(32'hA5));

    // Asynchronous reset between edges, then an edge under reset must not write.
    drive(32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0);  step("pre_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    chk("async_rst", 192'(obs), 192'(0));
    drive(32'h002081B3, 1'b1, 5'd1, 32'hDEAD, 1'b0); step("rst_no_write");
    rst = 1'b0;
    drive(32'h002081B3, 1'b0, 5'd0, 32'd0, 1'b0);  step("post_rst");
    chk("post_rst_x1", 192'(rd1E), 192'(0));

    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 5)];
      if (ri[6:0] == 7'h00) ri[6:0] = 7'($urandom);
      drive(ri, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
